ram_wr_port_sched: RTL

Write-port scheduler for the multi-ported register RAM (8R/4W class).
- Shares NWP physical write ports among NREQ write requesters using rotating-priority arbitration.
- Suppresses same-address collisions within a cycle.
- Provides an INIT sequencer that zero-fills the whole RAM through all write ports.
- Sits directly in front of the RAM write ports; read ports are untouched.

---
 rtl/ram_wr_port_sched_if.sv | 28 ++
 rtl/ram_wr_port_sched.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ram_wr_port_sched_if.sv
// Write-request and RAM write-port bundle for the write-port scheduler.
// The master side is the requester/initiator; the slave side is the scheduler.
interface ram_wr_port_sched_if #(
  parameter int NREQ  = 6,
  parameter int NWP   = 4,
  parameter int INDEX = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*INDEX-1:0] req_addr_i;
  logic [NREQ*WIDTH-1:0] req_data_i;
  logic [NREQ-1:0]       req_ready_o;
  logic                  init_i;
  logic                  busy_o;
  logic [NWP-1:0]        we_o;
  logic [NWP*INDEX-1:0]  addr_wr_o;
  logic [NWP*WIDTH-1:0]  data_wr_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i, init_i,
    input  req_ready_o, busy_o, we_o, addr_wr_o, data_wr_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, init_i,
    output req_ready_o, busy_o, we_o, addr_wr_o, data_wr_o
  );
endinterface

// File: rtl/ram_wr_port_sched.sv
// Rotating-priority write-port scheduler with same-address suppression
// and a zero-fill INIT sequencer for the multi-ported register RAM.
module ram_wr_port_sched #(
  parameter int NREQ  = 6,
  parameter int NWP   = 4,
  parameter int DEPTH = 16,
  parameter int INDEX = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_wr_port_sched_if.slave   bus
);

  localparam int NCYC = DEPTH / NWP;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic {RUN, INIT} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic [NWP-1:0]   we_q;
  logic [INDEX-1:0] wa_q [NWP];
  logic [WIDTH-1:0] wd_q [NWP];

  logic [NREQ-1:0]  gnt;
  logic [NWP-1:0]   pv;
  logic [INDEX-1:0] pa [NWP];
  logic [WIDTH-1:0] pd [NWP];
  logic [PW-1:0]    ptr_nxt;
  int               n;
  int               k;
  logic             hit;

  // Scan from ptr, granting up to NWP distinct addresses in order.
  always_comb begin
    gnt     = '0;
    pv      = '0;
    ptr_nxt = ptr;
    n       = 0;
    k       = 0;
    hit     = 1'b0;
    for (int j = 0; j < NWP; j++) begin
      pa[j] = '0;
      pd[j] = '0;
    end
    if (state == RUN && !bus.init_i) begin
      for (int i = 0; i < NREQ; i++) begin
        k = int'(ptr) + i;
        if (k >= NREQ) k = k - NREQ;
        hit = 1'b0;
        for (int j = 0; j < NWP; j++)
          if (j < n &&
              pa[j] == bus.req_addr_i[k*INDEX +: INDEX])
            hit = 1'b1;
        if (bus.req_valid_i[k] && n < NWP && !hit) begin
          gnt[k] = 1'b1;
          pv[n]  = 1'b1;
          pa[n]  = bus.req_addr_i[k*INDEX +: INDEX];
          pd[n]  = bus.req_data_i[k*WIDTH +: WIDTH];
          ptr_nxt = (k == NREQ - 1) ? '0 : PW'(k + 1);
          n = n + 1;
        end
      end
    end
  end

  // State, pointer, clear counter and registered RAM write ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      ptr    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      we_q   <= '0;
      for (int j = 0; j < NWP; j++) begin
        wa_q[j] <= '0;
        wd_q[j] <= '0;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (bus.init_i) begin
            state  <= INIT;
            cnt    <= '0;
            busy_q <= 1'b1;
            we_q   <= '0;
          end else begin
            we_q <= pv;
            ptr  <= ptr_nxt;
            for (int j = 0; j < NWP; j++)
              if (pv[j]) begin
                wa_q[j] <= pa[j];
                wd_q[j] <= pd[j];
              end
          end
        end
        INIT: begin
          we_q <= '1;
          for (int j = 0; j < NWP; j++) begin
            wa_q[j] <= INDEX'(int'(cnt) * NWP + j);
            wd_q[j] <= '0;
          end
          if (cnt == CW'(NCYC - 1)) begin
            state  <= RUN;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Ready is suppressed asynchronously while reset is asserted.
  always_comb begin
    bus.req_ready_o = reset ? '0 : gnt;
  end

  assign bus.busy_o = busy_q;
  assign bus.we_o   = we_q;

  for (genvar j = 0; j < NWP; j++) begin : g_pack
    assign bus.addr_wr_o[j*INDEX +: INDEX] = wa_q[j];
    assign bus.data_wr_o[j*WIDTH +: WIDTH] = wd_q[j];
  end

endmodule
